// File: rtl/grf_mp.sv
// Parametrised register file with NR combinational read ports, optional write bypass,
// per-register pending-producer counters for hazard detection and a registered write trace.
module grf_mp #(
   parameter int DW     = 32,
   parameter int AW     = 5,
   parameter int NR     = 2,
   parameter int PW     = 2,
   parameter int BYPASS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NR*AW-1:0] raddr,
   output logic [NR*DW-1:0] rdata,
   output logic [NR-1:0]    rbusy,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [DW-1:0]    wdata,
   input  logic [31:0]      wpc,
   input  logic             iss_en,
   input  logic [AW-1:0]    iss_addr,
   output logic             iss_ready,
   output logic             trace_valid,
   output logic [31:0]      trace_pc,
   output logic [AW-1:0]    trace_addr,
   output logic [DW-1:0]    trace_data,
   output logic             err
);

   localparam int DEPTH = 2 ** AW;
   localparam logic [PW-1:0] CNT_MAX = '1;

   logic [DW-1:0]    r_rf  [DEPTH];
   logic [PW-1:0]    r_cnt [DEPTH];
   logic             r_err;
   logic             r_trValid;
   logic [31:0]      r_trPc;
   logic [AW-1:0]    r_trAddr;
   logic [DW-1:0]    r_trData;

   logic             w_wcommit;
   logic             w_issAccept;
   logic [DEPTH-1:0] w_inc;
   logic [DEPTH-1:0] w_dec;

   assign w_wcommit   = we && (waddr != '0);
   assign iss_ready   = !reset || (iss_addr == '0) || (r_cnt[iss_addr] != CNT_MAX);
   assign w_issAccept = iss_en && iss_ready && (iss_addr != '0);

   always_comb begin
      w_inc = '0;
      w_dec = '0;
      for (int r = 1; r < DEPTH; r++) begin
         w_inc[r] = w_issAccept && (iss_addr == AW'(r));
         w_dec[r] = w_wcommit && (waddr == AW'(r));
      end
   end

   // Register 0 is never written or counted, so its storage and counter stay at their reset value of zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            r_rf[r]  <= '0;
            r_cnt[r] <= '0;
         end
         r_err     <= 1'b0;
         r_trValid <= 1'b0;
         r_trPc    <= '0;
         r_trAddr  <= '0;
         r_trData  <= '0;
      end else begin
         if (w_wcommit) begin
            r_rf[waddr] <= wdata;
            r_trPc      <= wpc;
            r_trAddr    <= waddr;
            r_trData    <= wdata;
         end
         r_trValid <= w_wcommit;
         for (int r = 1; r < DEPTH; r++) begin
            if (w_inc[r] && !w_dec[r]) begin
               r_cnt[r] <= r_cnt[r] + 1'b1;
            end else if (w_dec[r] && !w_inc[r]) begin
               if (r_cnt[r] == '0) begin
                  r_err <= 1'b1;
               end else begin
                  r_cnt[r] <= r_cnt[r] - 1'b1;
               end
            end
         end
      end
   end

   // Busy flags follow the registered counters only; a writeback does not clear them early.
   for (genvar k = 0; k < NR; k++) begin : g_rd
      logic [AW-1:0] w_ra;
      logic          w_byp;
      assign w_ra  = raddr[k*AW +: AW];
      assign w_byp = (BYPASS != 0) && w_wcommit && (waddr == w_ra);
      assign rdata[k*DW +: DW] = !reset ? '0 : (w_byp ? wdata : r_rf[w_ra]);
      assign rbusy[k] = reset && (r_cnt[w_ra] != '0);
   end

   assign trace_valid = r_trValid;
   assign trace_pc    = r_trPc;
   assign trace_addr  = r_trAddr;
   assign trace_data  = r_trData;
   assign err         = r_err;

endmodule

// File: tb/tb_grf_mp.sv
// Directed bench for grf_mp: a bypassing instance and a non-bypassing instance share all inputs.
module tb_grf_mp;

   logic        clk;
   logic        reset;
   logic [9:0]  raddr;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [31:0] wpc;
   logic        iss_en;
   logic [4:0]  iss_addr;

   logic [63:0] rdata,   rdataNb;
   logic [1:0]  rbusy,   rbusyNb;
   logic        issReady, issReadyNb;
   logic        trValid, trValidNb;
   logic [31:0] trPc,    trPcNb;
   logic [4:0]  trAddr,  trAddrNb;
   logic [31:0] trData,  trDataNb;
   logic        err,     errNb;

   int checks = 0;
   int errors = 0;

   grf_mp #(.DW(32), .AW(5), .NR(2), .PW(2), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .we(we), .waddr(waddr), .wdata(wdata), .wpc(wpc),
      .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(issReady),
      .trace_valid(trValid), .trace_pc(trPc), .trace_addr(trAddr), .trace_data(trData),
      .err(err)
   );

   grf_mp #(.DW(32), .AW(5), .NR(2), .PW(2), .BYPASS(0)) dutNb (
      .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdataNb), .rbusy(rbusyNb),
      .we(we), .waddr(waddr), .wdata(wdata), .wpc(wpc),
      .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(issReadyNb),
      .trace_valid(trValidNb), .trace_pc(trPcNb), .trace_addr(trAddrNb), .trace_data(trDataNb),
      .err(errNb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle 1ns after the edge so inputs change away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic iWe, input logic [4:0] iWaddr, input logic [31:0] iWdata,
                                input logic iIss, input logic [4:0] iIssAddr);
      we       = iWe;
      waddr    = iWaddr;
      wdata    = iWdata;
      iss_en   = iIss;
      iss_addr = iIssAddr;
      #1;
   endtask

   task automatic doReset();
      reset = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
      tick();
      reset = 1'b1;
      #1;
   endtask

   initial begin
      reset = 1'b0;
      raddr = '0;
      wpc   = '0;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
      checkOutput("rst_rdata", rdata, 64'h0);
      checkOutput("rst_rbusy", {62'h0, rbusy}, 64'h0);
      checkOutput("rst_issready", {63'h0, issReady}, 64'h1);
      checkOutput("rst_trvalid", {63'h0, trValid}, 64'h0);
      checkOutput("rst_err", {63'h0, err}, 64'h0);
      tick();
      reset = 1'b1;
      #1;

      // Basic write and trace
      wpc = 32'h3000;
      applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0);
      tick();
      raddr = {5'd0, 5'd5};
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      checkOutput("w5_rdata0", {32'h0, rdata[31:0]}, 64'h1234_5678);
      checkOutput("w5_trvalid", {63'h0, trValid}, 64'h1);
      checkOutput("w5_trpc", {32'h0, trPc}, 64'h3000);
      checkOutput("w5_traddr", {59'h0, trAddr}, 64'h5);
      checkOutput("w5_trdata", {32'h0, trData}, 64'h1234_5678);
      checkOutput("w5_err_unissued", {63'h0, err}, 64'h1);
      tick();
      checkOutput("w5_trvalid_drop", {63'h0, trValid}, 64'h0);

      // Write to r0 is ignored
      raddr = {5'd0, 5'd0};
      applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
      checkOutput("r0_bypass", rdata, 64'h0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      checkOutput("r0_rdata", rdata, 64'h0);
      checkOutput("r0_trvalid", {63'h0, trValid}, 64'h0);
      checkOutput("r0_err", {63'h0, err}, 64'h1);
      raddr = {5'd0, 5'd5};
      #1;
      checkOutput("r5_hold", {32'h0, rdata[31:0]}, 64'h1234_5678);

      // Same-cycle bypass versus stored value
      raddr = {5'd7, 5'd7};
      applyStimulus(1'b1, 5'd7, 32'hAA, 1'b0, 5'd0);
      checkOutput("byp_on", rdata, {32'hAA, 32'hAA});
      checkOutput("byp_off", rdataNb, 64'h0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      checkOutput("byp_off_after", rdataNb, {32'hAA, 32'hAA});

      // Counter saturation on r3
      doReset();
      raddr = {5'd0, 5'd3};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
         tick();
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
      checkOutput("r3_full_ready", {63'h0, issReady}, 64'h0);
      checkOutput("r3_busy", {63'h0, rbusy[0]}, 64'h1);
      tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5'd3, 32'h300 + i, 1'b0, 5'd3);
         checkOutput("r3_busy_wb", {63'h0, rbusy[0]}, 64'h1);
         tick();
         if (i == 0) checkOutput("r3_ready_again", {63'h0, issReady}, 64'h1);
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      checkOutput("r3_busy_clear", {63'h0, rbusy[0]}, 64'h0);
      checkOutput("r3_err", {63'h0, err}, 64'h0);
      checkOutput("r3_data", {32'h0, rdata[31:0]}, 64'h302);

      // Simultaneous issue and write on r9
      raddr = {5'd9, 5'd0};
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
      tick();
      applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      checkOutput("r9_both_busy", {63'h0, rbusy[1]}, 64'h1);
      applyStimulus(1'b1, 5'd9, 32'h9A, 1'b0, 5'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      checkOutput("r9_clear", {63'h0, rbusy[1]}, 64'h0);
      checkOutput("r9_err0", {63'h0, err}, 64'h0);
      applyStimulus(1'b1, 5'd9, 32'h9B, 1'b0, 5'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      checkOutput("r9_err1", {63'h0, err}, 64'h1);
      tick();
      tick();
      checkOutput("r9_err_sticky", {63'h0, err}, 64'h1);

      // Asynchronous reset in the middle of a cycle
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
         tick();
      end
      applyStimulus(1'b1, 5'd4, 32'h55, 1'b0, 5'd0);
      tick();
      applyStimulus(1'b1, 5'd10, 32'h10, 1'b0, 5'd0);
      tick();
      raddr = {5'd6, 5'd4};
      applyStimulus(1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
      checkOutput("pre_r4", {32'h0, rdata[31:0]}, 64'h55);
      checkOutput("pre_busy", {62'h0, rbusy}, 64'h1);
      checkOutput("pre_err", {63'h0, err}, 64'h1);
      checkOutput("pre_trvalid", {63'h0, trValid}, 64'h1);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("arst_rdata", rdata, 64'h0);
      checkOutput("arst_rbusy", {62'h0, rbusy}, 64'h0);
      checkOutput("arst_err", {63'h0, err}, 64'h0);
      checkOutput("arst_trvalid", {63'h0, trValid}, 64'h0);
      checkOutput("arst_issready", {63'h0, issReady}, 64'h1);
      tick();
      reset = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      checkOutput("post_lost_write", rdata, 64'h0);
      checkOutput("post_trvalid", {63'h0, trValid}, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
